tensor_store: RTL

- Parametrised parameter-tensor store for the RNN datapath: a ROWS x COLS array of DATA_W-bit words holding weights or biases.
- Keeps the random-access write and read ports of the earlier fixed-size stores.
- Adds three sequenced operations:
  - a bulk streaming loader with valid/ready and auto-incrementing address,
  - a row-streaming read-out towards the MAC units,
  - a multi-cycle clear sweep.
- Sits between the host parameter loader and the gate/MAC pipeline.

---
 rtl/tensor_store.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tensor_store.sv
// ROWS x COLS parameter-tensor store: random-access read/write ports plus
// sequenced bulk load, row stream-out and clear sweep.
module tensor_store #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              load_done,
    input  logic              row_start,
    input  logic [ROW_W-1:0]  row_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              cmd_err,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [ROWS][COLS];
    logic [ROW_W-1:0]  ptr_r;
    logic [COL_W-1:0]  ptr_c;
    logic [ROW_W-1:0]  str_row;
    logic [COL_W-1:0]  col_nxt;
    logic              wr_ok;
    logic              row_ok;
    logic              at_last;
    logic [DATA_W-1:0] first_word;

    // Both streams use valid/ready: a word transfers on any cycle where
    // valid and ready are both high; the producer holds its word until then.
    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_IDLE);

    assign wr_ok   = wr_en && !clear && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign row_ok  = (int'(row_sel) < ROWS);
    assign at_last = (ptr_r == LAST_ROW) && (ptr_c == LAST_COL);
    assign col_nxt = ptr_c + COL_W'(1);

    // A write landing on the first word of the row being launched is forwarded.
    assign first_word = (wr_ok && (wr_row == row_sel) && (wr_col == '0)) ?
                        wr_data : mem[row_sel][0];

    assign rd_data = ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) ?
                     mem[rd_row][rd_col] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr_r     <= '0;
            ptr_c     <= '0;
            str_row   <= '0;
            load_done <= 1'b0;
            cmd_err   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else begin
            load_done <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        mem[wr_row][wr_col] <= wr_data;
                    end
                    ptr_r <= '0;
                    ptr_c <= '0;
                    if (clear) begin
                        state <= S_CLEAR;
                    end else if (load_start) begin
                        state <= S_LOAD;
                    end else if (row_start) begin
                        if (row_ok) begin
                            state     <= S_STREAM;
                            str_row   <= row_sel;
                            out_valid <= 1'b1;
                            out_data  <= first_word;
                            out_last  <= (COLS == 1);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR, S_LOAD: begin
                    if (state == S_CLEAR || in_valid) begin
                        mem[ptr_r][ptr_c] <= (state == S_CLEAR) ? '0 : in_data;
                        if (at_last) begin
                            state     <= S_IDLE;
                            ptr_r     <= '0;
                            ptr_c     <= '0;
                            load_done <= (state == S_LOAD);
                        end else if (ptr_c == LAST_COL) begin
                            ptr_c <= '0;
                            ptr_r <= ptr_r + ROW_W'(1);
                        end else begin
                            ptr_c <= col_nxt;
                        end
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            ptr_c     <= '0;
                        end else begin
                            ptr_c    <= col_nxt;
                            out_data <= mem[str_row][col_nxt];
                            out_last <= (col_nxt == LAST_COL);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
